// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - LCD command constants, step indices and sequencer state encoding
package lcd_pkg;

   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_LINE1    = 8'h80;
   localparam logic [7:0] LCD_LINE2    = 8'hC0;

   localparam logic [5:0] REFRESH_FIRST = 6'd4;
   localparam logic [5:0] LINE2_STEP    = 6'd21;
   localparam logic [5:0] LAST_STEP     = 6'd37;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_START,
      ST_ARM,
      ST_WAIT,
      ST_DELAY
   } lcd_state_t;

   // Power-on command sequence, one command per init step.
   function automatic logic [7:0] init_cmd(input logic [5:0] idx);
      case (idx)
         6'd0:    return LCD_FUNC_SET;
         6'd1:    return LCD_DISP_ON;
         6'd2:    return LCD_CLEAR;
         default: return LCD_ENTRY;
      endcase
   endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// rtl/lcd_char_buf.sv - 32x8 display character buffer, synchronous write, combinational read
module lcd_char_buf
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [32];

   // Reset blanks the display to spaces; host writes land on the next clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            mem[i] <= 8'h20;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_seq_ctrl.sv
// rtl/lcd_seq_ctrl.sv - LCD init/refresh sequencer feeding the bus controller (option: LCD_AUTO_REFRESH_EN)
module lcd_seq_ctrl
   import lcd_pkg::*;
#(
   parameter logic [17:0] DLY_CYCLES = 18'd250000,
   parameter int          INIT_LEN   = 4
)(
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iWR,
   input  logic [4:0] iADDR,
   input  logic [7:0] iCHAR,
   input  logic       iREFRESH,
   output logic       oBUSY,
   output logic [7:0] oLCD_DATA,
   output logic       oLCD_RS,
   output logic       oLCD_START,
   input  logic       iLCD_DONE
);

   lcd_state_t  state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [17:0] cnt_q, cnt_d;
   logic        pending_q;
   logic [7:0]  data_q;
   logic        rs_q;
   logic        refresh_req;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_data;
   logic [7:0]  step_data;
   logic        step_rs;

`ifdef LCD_AUTO_REFRESH_EN
   assign refresh_req = iREFRESH | iWR;
`else
   assign refresh_req = iREFRESH;
`endif

   lcd_char_buf u_buf (
      .clk     (iCLK),
      .rst_n   (iRST_N),
      .wr_en   (iWR),
      .wr_addr (iADDR),
      .wr_data (iCHAR),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Map the step index onto a command constant or a buffer character.
   always_comb begin
      step_data = 8'h00;
      step_rs   = 1'b0;
      rd_addr   = idx_q[4:0] - ((idx_q < LINE2_STEP) ? 5'd5 : 5'd6);
      if (idx_q < 6'(INIT_LEN)) begin
         step_data = init_cmd(idx_q);
      end else if (idx_q == REFRESH_FIRST) begin
         step_data = LCD_LINE1;
      end else if (idx_q == LINE2_STEP) begin
         step_data = LCD_LINE2;
      end else begin
         step_rs   = 1'b1;
         step_data = rd_data;
      end
   end

   // Sequencer next-state: setup, start pulse, stale-done blanking, wait, settle delay.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (refresh_req || pending_q) begin
               idx_d   = REFRESH_FIRST;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_START;
         ST_START: begin
            cnt_d   = 18'd0;
            state_d = ST_ARM;
         end
         ST_ARM: begin
            if (cnt_q == 18'd1) begin
               cnt_d   = 18'd0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + 18'd1;
            end
         end
         ST_WAIT: begin
            if (iLCD_DONE) begin
               cnt_d   = 18'd0;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (cnt_q == DLY_CYCLES - 18'd1) begin
               cnt_d = 18'd0;
               if (idx_q == LAST_STEP) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 6'd1;
                  state_d = ST_SETUP;
               end
            end else begin
               cnt_d = cnt_q + 18'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, index and counter registers; reset restarts the full init sequence.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_SETUP;
         idx_q   <= 6'd0;
         cnt_q   <= 18'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Refresh requests arriving while busy collapse into a single pending pass.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         pending_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         pending_q <= 1'b0;
      end else if (refresh_req) begin
         pending_q <= 1'b1;
      end
   end

   // Latch the step byte at the end of SETUP so it holds through WAIT and DELAY.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         data_q <= 8'h00;
         rs_q   <= 1'b0;
      end else if (state_q == ST_SETUP) begin
         data_q <= step_data;
         rs_q   <= step_rs;
      end
   end

   assign oLCD_DATA  = data_q;
   assign oLCD_RS    = rs_q;
   assign oLCD_START = (state_q == ST_START);
   assign oBUSY      = (state_q != ST_IDLE) || pending_q || refresh_req;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb/tb_lcd_seq_ctrl.sv - scoreboard bench for lcd_seq_ctrl with a bus-controller model
module tb_lcd_seq_ctrl;

   localparam logic [17:0] DLY      = 18'd4;
   localparam int          DONE_LAT = 20;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       wr       = 1'b0;
   logic [4:0] addr     = 5'd0;
   logic [7:0] ch       = 8'd0;
   logic       refresh  = 1'b0;
   logic       lcd_done = 1'b1;
   logic       busy;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_start;

   int         checks   = 0;
   int         errors   = 0;
   int         n_starts = 0;
   int         cyc      = 0;
   logic [8:0] exp_q [$];
   logic [7:0] shadow [32];

   always #5 clk = ~clk;

   lcd_seq_ctrl #(.DLY_CYCLES(DLY), .INIT_LEN(4)) dut (
      .iCLK       (clk),
      .iRST_N     (rst_n),
      .iWR        (wr),
      .iADDR      (addr),
      .iCHAR      (ch),
      .iREFRESH   (refresh),
      .oBUSY      (busy),
      .oLCD_DATA  (lcd_data),
      .oLCD_RS    (lcd_rs),
      .oLCD_START (lcd_start),
      .iLCD_DONE  (lcd_done)
   );

   // Bus controller: done stays stale for 1-2 cycles after a start edge, then rises DONE_LAT later.
   initial begin : bus_model
      int   cnt;
      int   clr_at;
      logic prev;
      cnt = 1000; clr_at = 0; prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (lcd_start && !prev) begin
            cnt    = 0;
            clr_at = $urandom_range(1, 2);
         end else if (cnt < 1000) begin
            cnt++;
         end
         if (cnt == clr_at) lcd_done = 1'b0;
         if (cnt == DONE_LAT) lcd_done = 1'b1;
         prev = lcd_start;
      end
   end

   // Monitor: every start edge pops one expected {rs,byte}; also checks pulse width, spacing and busy.
   initial begin : monitor
      logic       prev_start;
      int         last_cyc;
      logic [8:0] e;
      prev_start = 1'b0; last_cyc = -1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_start = 1'b0;
            last_cyc   = -1;
         end else begin
            if (exp_q.size() > 0) begin
               checks++;
               if (!busy) begin
                  errors++;
                  $display("FAIL busy_hold: oBUSY=%0b with %0d bytes outstanding, required 1", busy, exp_q.size());
               end
            end
            if (lcd_start && prev_start) begin
               checks++;
               errors++;
               $display("FAIL start_width: oLCD_START high for 2+ cycles, required 1");
            end
            if (lcd_start && !prev_start) begin
               n_starts++;
               if (last_cyc >= 0) begin
                  checks++;
                  if (cyc - last_cyc < DONE_LAT + int'(DLY)) begin
                     errors++;
                     $display("FAIL start_gap: %0d cycles, required >= %0d", cyc - last_cyc, DONE_LAT + int'(DLY));
                  end
               end
               last_cyc = cyc;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_start: rs=%0b data=%02h, required no start", lcd_rs, lcd_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({lcd_rs, lcd_data} !== e) begin
                     errors++;
                     $display("FAIL byte: rs=%0b data=%02h, required rs=%0b data=%02h", lcd_rs, lcd_data, e[8], e[7:0]);
                  end
               end
            end
            prev_start = lcd_start;
         end
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Expected pass: optional init commands, line-1 address, 16 chars, line-2 address, 16 chars.
   task automatic push_pass(input bit full);
      logic [7:0] init [4];
      init = '{8'h38, 8'h0C, 8'h01, 8'h06};
      if (full) for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, init[i]});
      exp_q.push_back({1'b0, 8'h80});
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, shadow[i]});
      exp_q.push_back({1'b0, 8'hC0});
      for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, shadow[i]});
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_char(input logic [4:0] a, input logic [7:0] c);
      wr = 1'b1; addr = a; ch = c;
      shadow[a] = c;
      tick();
      wr = 1'b0;
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL idle_timeout: busy=%0b outstanding=%0d after %0d cycles, required idle", busy, exp_q.size(), n);
      end
   endtask

   task automatic wait_starts(input int target, input int budget);
      int n;
      n = 0;
      while (n_starts < target && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL start_timeout: starts=%0d, required %0d", n_starts, target);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      checks += 4;
      if (lcd_data !== 8'h00) begin errors++; $display("FAIL %s_data: %02h, required 00", tag, lcd_data); end
      if (lcd_rs !== 1'b0)    begin errors++; $display("FAIL %s_rs: %0b, required 0", tag, lcd_rs); end
      if (lcd_start !== 1'b0) begin errors++; $display("FAIL %s_start: %0b, required 0", tag, lcd_start); end
      if (busy !== 1'b1)      begin errors++; $display("FAIL %s_busy: %0b, required 1", tag, busy); end
   endtask

   initial begin : stimulus
      int base;
      int k;
      for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
      repeat (3) @(posedge clk);
      check_reset_outputs("reset");
      push_pass(1'b1);
      tick();
      rst_n = 1'b1;
      wait_idle(3000);

`ifdef LCD_AUTO_REFRESH_EN
      write_char(5'd16, 8'h41);
      push_pass(1'b0);
      wait_idle(3000);
`else
      write_char(5'd0, 8'h48);
      write_char(5'd1, 8'h45);
      write_char(5'd2, 8'h4C);
      write_char(5'd3, 8'h4C);
      write_char(5'd4, 8'h4F);
      write_char(5'd31, 8'h5A);
      push_pass(1'b0);
      pulse_refresh();
      wait_idle(3000);

      write_char(5'd7, 8'h71);
      repeat (5) tick();
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL no_auto_refresh: oBUSY=%0b after write, required 0", busy);
      end

      for (int p = 0; p < 3; p++) begin
         k = $urandom_range(1, 6);
         for (int w = 0; w < k; w++) write_char(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
         push_pass(1'b0);
         pulse_refresh();
         wait_idle(3000);
      end

      base = n_starts;
      push_pass(1'b0);
      pulse_refresh();
      wait_starts(base + 3, 2000);
      pulse_refresh();
      tick();
      pulse_refresh();
      push_pass(1'b0);
      wait_idle(5000);

      for (int w = 0; w < 4; w++) write_char(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
      base = n_starts;
      push_pass(1'b0);
      pulse_refresh();
      wait_starts(base + 9, 2000);
      repeat (3) tick();
      rst_n = 1'b0;
      exp_q.delete();
      check_reset_outputs("midreset");
      for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
      push_pass(1'b1);
      tick();
      rst_n = 1'b1;
      wait_idle(3000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_seq_ctrl.md
Name: lcd_seq_ctrl

Overview:
Command/character sequencer that sits directly upstream of the LCD bus controller (the iDATA/iRS/iStart/oDone write engine).
- After reset it issues the HD44780 init commands, then writes a 32-character display buffer: 2 lines x 16 chars.
- A host writes characters into the buffer and requests a refresh.
- Each byte is handed to the bus controller with a start pulse. The block waits for done, then inserts a command-settle delay.

Parameters:
DLY_CYCLES, 18'd250000, settle delay after each accepted command (5 ms at 50 MHz)
INIT_LEN, 4, number of init commands

Ports:
iCLK  in  1  clock
iRST_N  in  1  reset, asynchronous, active-low
iWR  in  1  buffer write strobe, one cycle
iADDR  in  5  buffer address: 0-15 line 1, 16-31 line 2
iCHAR  in  8  ASCII character to write
iREFRESH  in  1  refresh request, one cycle
oBUSY  out  1  high while init or refresh is in progress
oLCD_DATA  out  8  byte to bus controller
oLCD_RS  out  1  0 = command, 1 = data
oLCD_START  out  1  start pulse to bus controller
iLCD_DONE  in  1  done level from bus controller

Behaviour:
- Reset values:
  - oLCD_DATA=0, oLCD_RS=0, oLCD_START=0, oBUSY=1.
  - Step index=0, delay counter=0, pending=0.
  - All buffer entries=8'h20 (space).
- Reset mid-operation aborts immediately and restarts the full init sequence.
- Step table (6-bit index, 38 steps):
  - 0..3: 8'h38, 8'h0C, 8'h01, 8'h06, with RS=0.
  - 4: 8'h80, RS=0.
  - 5..20: buf[0..15], RS=1.
  - 21: 8'hC0, RS=0.
  - 22..37: buf[16..31], RS=1.
- After reset, steps run 0..37 (init plus refresh), then the FSM goes to IDLE.
- A refresh runs steps 4..37.
- FSM states:
  - IDLE: oBUSY=0. iREFRESH or pending → index=4, go to SETUP, clear pending, oBUSY=1.
  - SETUP: drive oLCD_DATA/oLCD_RS from the table at the index; hold 1 cycle.
  - START: oLCD_START=1 for exactly 1 cycle. Data/RS stay stable from SETUP through WAIT.
  - ARM: oLCD_START=0 for 2 cycles; iLCD_DONE is ignored. This covers the stale done from the previous byte, which the bus controller clears 1-2 cycles after the rising start.
  - WAIT: wait for iLCD_DONE=1; no timeout.
  - DELAY: count 0..DLY_CYCLES-1. Then, if index=37 go to IDLE; otherwise increment index and go to SETUP.
- Handshake: only rising edges of oLCD_START matter downstream. START is always preceded by ≥1 low cycle.
- Buffer writes are accepted in every state, including reset-release cycle+1.
  - A write takes effect on the next clock.
  - A character already sent in the current pass is not re-sent.
  - Simultaneous write and read of the same address: the step reads the old value.
- iREFRESH while oBUSY=1 sets pending, which saturates at 1. One extra refresh starts from IDLE on the cycle after completion.
- iREFRESH together with the final DELAY cycle also sets pending.
- Delay counter width is 18 bits; DLY_CYCLES must be ≥1.

Optional Feature:
LCD_AUTO_REFRESH_EN
- Defined: every iWR also acts as iREFRESH (sets pending, or starts from IDLE).
- Undefined: the display changes only on explicit iREFRESH.

Decomposition:
- Package lcd_pkg:
  - command constants: LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ENTRY=8'h06, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - FSM state encoding (3-bit).
  - step-index constants: REFRESH_FIRST=4, LAST_STEP=37.
- Sub-module lcd_char_buf:
  - 32x8 register file with synchronous write and combinational read.
  - Reset fills with 8'h20.

Test Plan:
- Reset release, DLY_CYCLES=4, behavioural bus-controller model (done 20 cycles after start edge) → 38 start pulses: first 5 bytes 38,0C,01,06,80 with RS=0; 16 x 20 with RS=1; C0; 16 x 20. Then oBUSY falls.
- Write "HELLO" to addr 0-4 and 'Z' to addr 31, then iREFRESH → 80, 48,45,4C,4C,4F, 11 x 20, C0, 15 x 20, 5A.
- iREFRESH twice during a refresh → exactly one extra 34-step pass; oBUSY stays high between passes.
- iLCD_DONE held high (stale) when START fires → no advance until done drops and rises again; gap between starts ≥ DLY_CYCLES+4.
- Assert iRST_N low mid-refresh at step 12 → outputs return to reset values; sequence restarts at 8'h38; buffer is all spaces.
- With LCD_AUTO_REFRESH_EN, a single iWR addr 16 'A' in IDLE → refresh starts without iREFRESH; step 22 sends 8'h41.
